v_notify_coalesce: RTL

// - Receiving end of the lv0 notify bus driven by the update pipeline.
// - The notify bus has no backpressure, so each notification is absorbed

---
 rtl/cfg_pkg.sv | 4 +
 rtl/v_pkg.sv | 14 +
 rtl/v_notify_coalesce_fifo.sv | 53 +++++
 rtl/v_notify_coalesce.sv | 98 +++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Build-wide configuration shared by the lv0 notify path.
package cfg_pkg;
  localparam int unsigned PROD_N = 8;
endpackage

// File: rtl/v_pkg.sv
// Common types for the lv0 notify bus and its egress beat.
package v_pkg;
  localparam int unsigned ID_W = (cfg_pkg::PROD_N > 1) ? $clog2(cfg_pkg::PROD_N) : 1;

  typedef logic [ID_W-1:0] id_t;
  typedef logic [15:0]     key_t;
  typedef logic [15:0]     size_t;

  typedef struct packed {
    id_t   prod_id;
    key_t  key;
    size_t size;
  } ntf_t;
endpackage

// File: rtl/v_notify_coalesce_fifo.sv
// Product-ID FIFO, flop storage; pointers carry a wrap bit to tell full from empty.
module v_notify_coalesce_fifo
  import v_pkg::*;
#(
  parameter int unsigned DEPTH = cfg_pkg::PROD_N
) (
  input  logic clk,
  input  logic arst_n,
  input  logic push,
  input  id_t  push_id,
  input  logic pop,
  output id_t  head_id,
  output logic empty,
  output logic full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW:0] ptr_t;

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  id_t  mem [DEPTH];

  // Low bits wrap at DEPTH-1 so non-power-of-two depths still work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p[AW-1:0] == AW'(DEPTH - 1)) begin
      r     = '0;
      r[AW] = ~p[AW];
    end else begin
      r = p + 1'b1;
    end
    return r;
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_id = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_id;
  end
endmodule

// File: rtl/v_notify_coalesce.sv
// Absorbs lv0 notifications into a per-product table and replays pending
// products in first-notified order on a valid/ready egress.
module v_notify_coalesce
  import v_pkg::*;
#(
  parameter int unsigned PROD_N = cfg_pkg::PROD_N,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_lv0_vld_r,
  input  id_t              i_lv0_prod_id_r,
  input  key_t             i_lv0_key_r,
  input  size_t            i_lv0_size_r,
  output logic             o_ntf_vld_r,
  input  logic             i_ntf_rdy,
  output id_t              o_ntf_prod_id_r,
  output key_t             o_ntf_key_r,
  output size_t            o_ntf_size_r,
  output logic [CNT_W-1:0] o_coalesce_cnt_r
);
  logic [PROD_N-1:0] pend;
  logic [PROD_N-1:0] pend_nxt;
  key_t              tbl_key  [PROD_N];
  size_t             tbl_size [PROD_N];
  ntf_t              egr;
  logic              egr_vld;
  logic [CNT_W-1:0]  cnt;

  id_t  head_id;
  logic fifo_empty;
  logic fifo_full_unused;
  logic pop;
  logic push;
  logic collide;
  logic hit_pend;
  logic coalesce;

  assign pop      = ~fifo_empty & (~egr_vld | i_ntf_rdy);
  assign hit_pend = pend[i_lv0_prod_id_r];
  assign collide  = pop && (head_id == i_lv0_prod_id_r);
  // A collision with the popping head re-queues the product rather than coalescing.
  assign push     = i_lv0_vld_r & (~hit_pend | collide);
  assign coalesce = i_lv0_vld_r & hit_pend & ~collide;

  v_notify_coalesce_fifo #(.DEPTH(PROD_N)) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push    (push),
    .push_id (i_lv0_prod_id_r),
    .pop     (pop),
    .head_id (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full_unused)
  );

  always_comb begin
    pend_nxt = pend;
    if (pop)         pend_nxt[head_id]         = 1'b0;
    if (i_lv0_vld_r) pend_nxt[i_lv0_prod_id_r] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) pend <= '0;
    else         pend <= pend_nxt;
  end

  always_ff @(posedge clk) begin
    if (i_lv0_vld_r) begin
      tbl_key[i_lv0_prod_id_r]  <= i_lv0_key_r;
      tbl_size[i_lv0_prod_id_r] <= i_lv0_size_r;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      egr     <= '0;
      egr_vld <= 1'b0;
      cnt     <= '0;
    end else begin
      if (pop) begin
        egr.prod_id <= head_id;
        egr.key     <= tbl_key[head_id];
        egr.size    <= tbl_size[head_id];
        egr_vld     <= 1'b1;
      end else if (i_ntf_rdy) begin
        egr_vld <= 1'b0;
      end
      if (coalesce && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  assign o_ntf_vld_r      = egr_vld;
  assign o_ntf_prod_id_r  = egr.prod_id;
  assign o_ntf_key_r      = egr.key;
  assign o_ntf_size_r     = egr.size;
  assign o_coalesce_cnt_r = cnt;
endmodule
